// File: rtl/ps2_scan_code_receiver.sv
// rtl/ps2_scan_code_receiver.sv - PS/2 device-to-host receiver folding E0/F0 prefixes into key flags
// Define PS2_PARITY_CHECK_EN to reject frames with bad odd parity; otherwise the parity bit is ignored.
module ps2_scan_code_receiver #(
   parameter int FILTER_CYCLES  = 8,
   parameter int TIMEOUT_CYCLES = 5000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] scan_code,
   output logic       scan_valid,
   output logic       key_release,
   output logic       key_extended,
   output logic       frame_error
);
   localparam int FW = $clog2(FILTER_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_CYCLES - 1);
   localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
   state_t state, state_next;

   logic          clk_s1, clk_s2, dat_s1, dat_s2, clk_filt;
   logic [FW-1:0] filt_cnt;
   logic [TW-1:0] to_cnt;
   logic [7:0]    shift;
   logic [2:0]    bit_cnt;
   logic          ext_pending, brk_pending;
   logic          fall, timeout, parity_ok, start_bit, shift_en, accept, err;

   // Lines idle high, so the synchronisers and filter come out of reset at 1.
   always_ff @(posedge clock) begin
      if (reset) begin
         clk_s1   <= 1'b1;
         clk_s2   <= 1'b1;
         dat_s1   <= 1'b1;
         dat_s2   <= 1'b1;
         clk_filt <= 1'b1;
         filt_cnt <= '0;
      end else begin
         clk_s1 <= ps2_clk;
         clk_s2 <= clk_s1;
         dat_s1 <= ps2_data;
         dat_s2 <= dat_s1;
         if (clk_s2 == clk_filt) begin
            filt_cnt <= '0;
         end else if (filt_cnt == FILT_MAX) begin
            clk_filt <= clk_s2;
            filt_cnt <= '0;
         end else begin
            filt_cnt <= filt_cnt + FW'(1);
         end
      end
   end

   assign fall    = clk_filt & ~clk_s2 & (filt_cnt == FILT_MAX);
   assign timeout = (state != IDLE) & ~fall & (to_cnt == TO_MAX);

`ifdef PS2_PARITY_CHECK_EN
   logic parity_bit;
   assign parity_ok = ^{shift, parity_bit};
`else
   assign parity_ok = 1'b1;
`endif

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (timeout) begin
         state_next = IDLE;
      end else if (fall) begin
         case (state)
            IDLE:    if (!dat_s2) state_next = DATA;
            DATA:    if (bit_cnt == 3'd7) state_next = PARITY;
            PARITY:  state_next = STOP;
            STOP:    state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   always_comb begin
      start_bit = 1'b0;
      shift_en  = 1'b0;
      accept    = 1'b0;
      err       = timeout;
      if (fall) begin
         case (state)
            IDLE:    if (dat_s2) err = 1'b1; else start_bit = 1'b1;
            DATA:    shift_en = 1'b1;
            STOP:    if (dat_s2 && parity_ok) accept = 1'b1; else err = 1'b1;
            default: ;
         endcase
      end
   end

   // Inter-edge watchdog: only runs while a frame is in flight.
   always_ff @(posedge clock) begin
      if (reset || state == IDLE || fall || timeout) to_cnt <= '0;
      else                                           to_cnt <= to_cnt + TW'(1);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         shift        <= 8'h00;
         bit_cnt      <= 3'd0;
         ext_pending  <= 1'b0;
         brk_pending  <= 1'b0;
         scan_code    <= 8'h00;
         key_release  <= 1'b0;
         key_extended <= 1'b0;
         scan_valid   <= 1'b0;
         frame_error  <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
         parity_bit   <= 1'b0;
`endif
      end else begin
         scan_valid  <= 1'b0;
         frame_error <= err;
         if (start_bit) bit_cnt <= 3'd0;
         if (shift_en) begin
            shift   <= {dat_s2, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
         end
`ifdef PS2_PARITY_CHECK_EN
         if (fall && state == PARITY) parity_bit <= dat_s2;
`endif
         if (err) begin
            ext_pending <= 1'b0;
            brk_pending <= 1'b0;
         end else if (accept) begin
            if (shift == 8'hE0) begin
               ext_pending <= 1'b1;
            end else if (shift == 8'hF0) begin
               brk_pending <= 1'b1;
            end else begin
               scan_code    <= shift;
               key_release  <= brk_pending;
               key_extended <= ext_pending;
               scan_valid   <= 1'b1;
               ext_pending  <= 1'b0;
               brk_pending  <= 1'b0;
            end
         end
      end
   end
endmodule

// File: tb/tb_ps2_scan_code_receiver.sv
// tb/tb_ps2_scan_code_receiver.sv - directed bench for ps2_scan_code_receiver (honours PS2_PARITY_CHECK_EN)
module tb_ps2_scan_code_receiver;
   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic [7:0] scan_code;
   logic       scan_valid, key_release, key_extended, frame_error;

   int n_cmp = 0;
   int n_mis = 0;
   int valid_cnt = 0;
   int err_cnt = 0;
   int v0, e0;
   logic long_valid = 1'b0, long_err = 1'b0, overlap = 1'b0;
   logic prev_v = 1'b0, prev_e = 1'b0;

   ps2_scan_code_receiver dut (
      .clock        (clock),
      .reset        (reset),
      .ps2_clk      (ps2_clk),
      .ps2_data     (ps2_data),
      .scan_code    (scan_code),
      .scan_valid   (scan_valid),
      .key_release  (key_release),
      .key_extended (key_extended),
      .frame_error  (frame_error)
   );

   always #5 clock = ~clock;

   always @(negedge clock) begin
      if (scan_valid) valid_cnt++;
      if (frame_error) err_cnt++;
      if (scan_valid && prev_v) long_valid = 1'b1;
      if (frame_error && prev_e) long_err = 1'b1;
      if (scan_valid && frame_error) overlap = 1'b1;
      prev_v = scan_valid;
      prev_e = frame_error;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic send_bit(input logic b);
      ps2_data = b;
      wait_cyc(10);
      ps2_clk = 1'b0;
      wait_cyc(20);
      ps2_clk = 1'b1;
      wait_cyc(10);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic pflip, input logic stop);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit((~^b) ^ pflip);
      send_bit(stop);
      ps2_data = 1'b1;
      wait_cyc(20);
   endtask

   task automatic mark;
      v0 = valid_cnt;
      e0 = err_cnt;
   endtask

   initial begin
      wait_cyc(5);
      reset = 1'b0;
      wait_cyc(2);
      check("rst_code", scan_code, 8'h00);
      check("rst_valid", scan_valid, 1'b0);
      check("rst_rel", key_release, 1'b0);
      check("rst_ext", key_extended, 1'b0);
      check("rst_err", frame_error, 1'b0);

      mark();
      send_frame(8'h1C, 1'b0, 1'b1);
      check("1c_valid_cnt", valid_cnt - v0, 1);
      check("1c_err_cnt", err_cnt - e0, 0);
      check("1c_code", scan_code, 8'h1C);
      check("1c_rel", key_release, 1'b0);
      check("1c_ext", key_extended, 1'b0);

      mark();
      send_frame(8'hF0, 1'b0, 1'b1);
      check("f0_no_valid", valid_cnt - v0, 0);
      send_frame(8'h1C, 1'b0, 1'b1);
      check("brk_valid_cnt", valid_cnt - v0, 1);
      check("brk_code", scan_code, 8'h1C);
      check("brk_rel", key_release, 1'b1);
      check("brk_ext", key_extended, 1'b0);

      mark();
      send_frame(8'hE0, 1'b0, 1'b1);
      send_frame(8'hF0, 1'b0, 1'b1);
      send_frame(8'h75, 1'b0, 1'b1);
      check("ext_valid_cnt", valid_cnt - v0, 1);
      check("ext_code", scan_code, 8'h75);
      check("ext_ext", key_extended, 1'b1);
      check("ext_rel", key_release, 1'b1);
      send_frame(8'h1C, 1'b0, 1'b1);
      check("after_ext_code", scan_code, 8'h1C);
      check("after_ext_rel", key_release, 1'b0);
      check("after_ext_ext", key_extended, 1'b0);
      check("ext_err_cnt", err_cnt - e0, 0);

      mark();
      send_frame(8'h32, 1'b1, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
      check("par_err_cnt", err_cnt - e0, 1);
      check("par_valid_cnt", valid_cnt - v0, 0);
      check("par_code", scan_code, 8'h1C);
`else
      check("par_err_cnt", err_cnt - e0, 0);
      check("par_valid_cnt", valid_cnt - v0, 1);
      check("par_code", scan_code, 8'h32);
`endif

      mark();
      send_frame(8'h4D, 1'b0, 1'b0);
      check("stop_err_cnt", err_cnt - e0, 1);
      check("stop_valid_cnt", valid_cnt - v0, 0);

      mark();
      send_bit(1'b1);
      wait_cyc(20);
      check("start_err_cnt", err_cnt - e0, 1);
      check("start_valid_cnt", valid_cnt - v0, 0);

      mark();
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b1);
      ps2_data = 1'b1;
      wait_cyc(5010);
      check("to_err_cnt", err_cnt - e0, 1);
      check("to_valid_cnt", valid_cnt - v0, 0);
      send_frame(8'h21, 1'b0, 1'b1);
      check("to_next_code", scan_code, 8'h21);
      check("to_next_err", err_cnt - e0, 1);

      send_bit(1'b0);
      send_bit(1'b0);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b1);
      reset = 1'b1;
      wait_cyc(3);
      reset = 1'b0;
      ps2_data = 1'b1;
      wait_cyc(2);
      check("mid_rst_code", scan_code, 8'h00);
      mark();
      send_frame(8'h24, 1'b0, 1'b1);
      check("mid_rst_next_code", scan_code, 8'h24);
      check("mid_rst_no_err", err_cnt - e0, 0);

      mark();
      ps2_clk = 1'b0;
      wait_cyc(2);
      ps2_clk = 1'b1;
      wait_cyc(20);
      ps2_clk = 1'b0;
      wait_cyc(7);
      ps2_clk = 1'b1;
      wait_cyc(20);
      check("glitch_err", err_cnt - e0, 0);
      check("glitch_valid", valid_cnt - v0, 0);
      send_frame(8'h1C, 1'b0, 1'b1);
      check("glitch_next_code", scan_code, 8'h1C);
      check("glitch_next_err", err_cnt - e0, 0);

      check("valid_one_cycle", long_valid, 1'b0);
      check("err_one_cycle", long_err, 1'b0);
      check("valid_err_overlap", overlap, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
